// File: rtl/ins_cache_if.sv
// Fetcher-facing and memory-facing signal bundle for the instruction cache.
// Carries the fetch handshake, the memory request/done handshake and the en/flush controls.
// The slave modport is the cache; the master modport is the fetcher plus memory controller.
interface ins_cache_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int INS_WIDTH  = 32
);
  logic                  en;
  logic                  flush;
  logic                  ins_call;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  ins_get;
  logic [INS_WIDTH-1:0]  ins_out;
  logic                  busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_done;
  logic [INS_WIDTH-1:0]  mem_data;

  modport slave (
    input  en, flush, ins_call, addr_in, mem_done, mem_data,
    output ins_get, ins_out, busy, mem_req, mem_addr
  );

  modport master (
    output en, flush, ins_call, addr_in, mem_done, mem_data,
    input  ins_get, ins_out, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and memory.
// Latency: hit answers two edges after the request is driven; a miss adds the memory round trip.
// Backpressure: one outstanding request; ins_call while busy is ignored; en=0 freezes everything.
module ins_cache #(
  parameter int ADDR_WIDTH  = 17,
  parameter int INS_WIDTH   = 32,
  parameter int INDEX_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  ins_cache_if.slave bus
);

  localparam int TAG_W = ADDR_WIDTH - 2 - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORD_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

  state_t                 state;
  logic [WORD_W-1:0]      req_word;     // word address of the request in flight
  logic                   flush_seen;   // a flush hit the current MISS; do not install its line
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [INS_WIDTH-1:0]   data_mem [LINES];

  logic                   ins_get_r;
  logic [INS_WIDTH-1:0]   ins_out_r;
  logic                   busy_r;
  logic                   mem_req_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   install;

  assign req_idx = req_word[INDEX_WIDTH-1:0];
  assign req_tag = req_word[WORD_W-1:INDEX_WIDTH];

  assign bus.ins_get  = ins_get_r;
  assign bus.ins_out  = ins_out_r;
  assign bus.busy     = busy_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = mem_addr_r;

  // Tag compare for the latched request; a same-cycle flush is folded in by the FSM.
  always_comb begin
    hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  end

  // A fill is written only if no flush touched this miss, including the completing edge.
  always_comb begin
    install = bus.en && (state == MISS) && bus.mem_done && !flush_seen && !bus.flush;
  end

  // Tag and data arrays: written on a clean fill, never reset.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus.mem_data;
    end
  end

  // Valid bits: flush wipes everything and wins over a coincident fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (bus.en) begin
      if (bus.flush) begin
        valid <= '0;
      end else if (install) begin
        valid[req_idx] <= 1'b1;
      end
    end
  end

  // Request FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_word   <= '0;
      flush_seen <= 1'b0;
      ins_get_r  <= 1'b0;
      ins_out_r  <= '0;
      busy_r     <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
    end else if (bus.en) begin
      ins_get_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ins_call) begin
            req_word <= bus.addr_in[ADDR_WIDTH-1:2];
            busy_r   <= 1'b1;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit && !bus.flush) begin
            ins_out_r <= data_mem[req_idx];
            ins_get_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= {req_word, 2'b00};
            flush_seen <= 1'b0;
            state      <= MISS;
          end
        end
        MISS: begin
          if (bus.flush) begin
            flush_seen <= 1'b1;
          end
          if (bus.mem_done) begin
            mem_req_r <= 1'b0;
            ins_out_r <= bus.mem_data;
            ins_get_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_cache.sv
// Randomized and directed bench for ins_cache against a line-table reference model.
// Inputs are driven and outputs sampled on the falling edge.
// Memory responses are generated by the bench with random delays.
module tb_ins_cache;

  localparam int AW = 17;
  localparam int DW = 32;

  logic clk;
  logic rst;

  ins_cache_if #(.ADDR_WIDTH(AW), .INS_WIDTH(DW)) bus ();

  ins_cache #(.ADDR_WIDTH(AW), .INS_WIDTH(DW), .INDEX_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what each of the 256 lines currently holds.
  bit          m_valid [256];
  logic [6:0]  m_tag   [256];
  logic [31:0] m_data  [256];
  logic [31:0] last_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_flush();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic flush_idle();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_flush();
    chk("flush_idle_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  // One complete fetch. flush_at: wait cycle (0..dly) on which flush is pulsed during
  // the miss, dly meaning together with mem_done; -1 for none. freeze_at: wait cycle
  // before which en is held low for 5 cycles; -1 for none. lflush: flush during lookup.
  task automatic fetch(input logic [AW-1:0] a, input logic [31:0] mdat, input int dly,
                       input int flush_at, input int freeze_at, input bit lflush);
    int          idx;
    logic [6:0]  tg;
    bit          hit;
    bit          fl_seen;
    idx = int'(a[9:2]);
    tg  = a[16:10];
    fl_seen = 1'b0;
    bus.ins_call = 1'b1;
    bus.addr_in  = a;
    @(negedge clk);
    bus.ins_call = 1'b0;
    bus.addr_in  = AW'($urandom);
    chk("get_drop", {63'd0, bus.ins_get}, 64'd0);
    chk("out_hold", {32'd0, bus.ins_out}, {32'd0, last_out});
    chk("busy_lookup", {63'd0, bus.busy}, 64'd1);
    if (lflush) begin
      bus.flush = 1'b1;
      model_flush();
    end
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    bus.flush = 1'b0;
    if (hit) begin
      chk("hit_get", {63'd0, bus.ins_get}, 64'd1);
      chk("hit_data", {32'd0, bus.ins_out}, {32'd0, m_data[idx]});
      chk("hit_noreq", {63'd0, bus.mem_req}, 64'd0);
      chk("hit_busy", {63'd0, bus.busy}, 64'd0);
      last_out = m_data[idx];
    end else begin
      chk("miss_req", {63'd0, bus.mem_req}, 64'd1);
      chk("miss_addr", {47'd0, bus.mem_addr}, {47'd0, a[16:2], 2'b00});
      chk("miss_noget", {63'd0, bus.ins_get}, 64'd0);
      for (int c = 0; c < dly; c++) begin
        if (c == freeze_at) begin
          bus.en = 1'b0;
          for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            chk("frz_req", {63'd0, bus.mem_req}, 64'd1);
            chk("frz_busy", {63'd0, bus.busy}, 64'd1);
            chk("frz_get", {63'd0, bus.ins_get}, 64'd0);
          end
          bus.en = 1'b1;
        end
        if (c == flush_at) begin
          bus.flush = 1'b1;
          fl_seen = 1'b1;
          model_flush();
        end
        @(negedge clk);
        bus.flush = 1'b0;
        chk("wait_req", {63'd0, bus.mem_req}, 64'd1);
        chk("wait_addr", {47'd0, bus.mem_addr}, {47'd0, a[16:2], 2'b00});
        chk("wait_noget", {63'd0, bus.ins_get}, 64'd0);
      end
      if (flush_at == dly) begin
        bus.flush = 1'b1;
        fl_seen = 1'b1;
        model_flush();
      end
      bus.mem_done = 1'b1;
      bus.mem_data = mdat;
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.flush    = 1'b0;
      bus.mem_data = DW'($urandom);
      chk("done_get", {63'd0, bus.ins_get}, 64'd1);
      chk("done_data", {32'd0, bus.ins_out}, {32'd0, mdat});
      chk("done_noreq", {63'd0, bus.mem_req}, 64'd0);
      chk("done_busy", {63'd0, bus.busy}, 64'd0);
      last_out = mdat;
      if (!fl_seen) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = mdat;
      end
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    int            dly;
    int            fa;
    int            za;
    bit            lf;

    bus.en = 1'b1;
    bus.flush = 1'b0;
    bus.ins_call = 1'b0;
    bus.addr_in = '0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    model_flush();
    last_out = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_get", {63'd0, bus.ins_get}, 64'd0);
    chk("rst_out", {32'd0, bus.ins_out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_addr", {47'd0, bus.mem_addr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then re-fetch hit.
    fetch(17'h00010, 32'h00500093, 3, -1, -1, 1'b0);
    fetch(17'h00010, 32'hDEADBEEF, 0, -1, -1, 1'b0);
    // Conflict on index 4: three misses, last fill wins.
    fetch(17'h00410, 32'h11111111, 1, -1, -1, 1'b0);
    fetch(17'h00010, 32'h00500093, 2, -1, -1, 1'b0);
    fetch(17'h00010, 32'h0, 0, -1, -1, 1'b0);
    // Flush in idle forces a miss; flush during a miss returns data but does not install.
    flush_idle();
    fetch(17'h00010, 32'h22222222, 2, -1, -1, 1'b0);
    fetch(17'h00014, 32'h33333333, 3, 1, -1, 1'b0);
    fetch(17'h00014, 32'h44444444, 1, -1, -1, 1'b0);
    fetch(17'h00014, 32'h0, 0, -1, -1, 1'b0);
    // Flush together with lookup forces a miss on a present line.
    fetch(17'h00014, 32'h55555555, 1, -1, -1, 1'b1);
    // Freeze mid-miss for 5 cycles.
    fetch(17'h00020, 32'h66666666, 3, -1, 1, 1'b0);
    fetch(17'h00020, 32'h0, 0, -1, -1, 1'b0);

    // Reset during a miss: outputs drop at once, nothing returned later.
    bus.ins_call = 1'b1;
    bus.addr_in  = 17'h00030;
    @(negedge clk);
    bus.ins_call = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {63'd0, bus.mem_req}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h77777777;
    @(negedge clk);
    bus.mem_done = 1'b0;
    rst = 1'b1;
    model_flush();
    last_out = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_noget", {63'd0, bus.ins_get}, 64'd0);
      chk("post_rst_noreq", {63'd0, bus.mem_req}, 64'd0);
    end
    // Formerly hit address must miss now.
    fetch(17'h00020, 32'h88888888, 2, -1, -1, 1'b0);

    // Randomized phase on a small address pool to mix hits, conflicts and flushes.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) == 0) flush_idle();
      ra = {7'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 2'($urandom)};
      dly = $urandom_range(0, 4);
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, dly) : -1;
      za = ($urandom_range(0, 9) == 0 && dly > 0) ? $urandom_range(0, dly - 1) : -1;
      if (za == fa) za = -1;
      lf = ($urandom_range(0, 15) == 0);
      fetch(ra, $urandom, dly, fa, za, lf);
    end

    @(negedge clk);
    chk("final_get_drop", {63'd0, bus.ins_get}, 64'd0);
    chk("final_idle", {63'd0, bus.busy}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
